ttt_turn_ctrl: RTL
==================

// Module: ttt_turn_ctrl
// PURPOSE
//  Game sequencer for the tic-tac-toe datapath.
//  - Arbitrates move requests from player X and player O; only the player whose turn it is may move.
//  - Validates each move, writes it into the 3x3 board register and pulses store_result on commit.
//  - Evaluates win/draw, alternates turns, and holds the final result until a new game is requested.
// PARAMETERS
//  FIRST_PLAYER  1'b0  player who moves first after reset/new_game (0=X, 1=O)
//  MAX_MOVES     9     move count that declares a draw when there is no win
// PORTS
//  clock         in   1   system clock, all state on rising edge
//  reset_b       in   1   asynchronous reset, active-high
//  new_game      in   1   sync clear of board/result; top priority over every state
//  go_x          in   1   X move request, level (button)
//  sel_x         in   4   X target cell 0..8 (row-major)
//  go_o          in   1   O move request, level (button)
//  sel_o         in   4   O target cell 0..8
//  board         out  18  cell i = board[2i+1:2i]: 00 empty, 01 X, 10 O
//  turn          out  1   player to move (0=X, 1=O)
//  store_result  out  1   1-cycle pulse, move committed this cycle
//  illegal       out  1   1-cycle pulse, request rejected
//  game_over     out  1   high while in OVER
//  winner        out  2   00 none/draw, 01 X, 10 O; valid when game_over=1
//  draw          out  1   high in OVER when no winner
// BEHAVIOUR
//  Reset (reset_b=1, async):
//   state=IDLE, board=0, turn=FIRST_PLAYER, move_cnt=0, winner=00.
//   All pulses 0, game_over=0, draw=0.
//  States: IDLE, CHECK, COMMIT, EVAL, WAIT_REL, OVER (Moore; outputs decode registered state).
//  IDLE:     active player's go=1 -> latch that player's sel into sel_q -> CHECK.
//            Inactive player's go is ignored, including when both go inputs are high.
//  CHECK:    sel_q>8 or cell sel_q non-empty -> illegal=1 for 1 cycle (Mealy) -> WAIT_REL.
//            Otherwise -> COMMIT.
//  COMMIT:   store_result=1.
//            At the clock edge: cell sel_q <= turn ? 10 : 01; move_cnt++; -> EVAL.
//  EVAL:     evaluate the updated board for a line of the mover (3 rows, 3 cols, 2 diagonals).
//            - Line found -> winner <= mover code -> OVER.
//            - Else move_cnt==MAX_MOVES -> winner <= 00 -> OVER (draw).
//            - Else turn <= ~turn -> WAIT_REL.
//  WAIT_REL: hold until the mover's go==0, then -> IDLE.
//            Prevents one press from committing twice; the mover is the player who owned the turn at the request.
//  OVER:     game_over=1; draw=(winner==00); go inputs ignored; board frozen.
//  new_game=1 in any state:
//   - next edge: board=0, move_cnt=0, winner=00, turn=FIRST_PLAYER, state=IDLE.
//   - no store_result/illegal pulse that cycle, even mid-COMMIT (the move is discarded).
//  Latency: go sampled in IDLE at edge t.
//   - store_result high during cycle t+2; board shows the move from t+3.
//   - game_over high from t+4 on a winning/drawing move.
//  Width rules: move_cnt is 4 bits and saturates at MAX_MOVES. sel values 9..15 are illegal (never wrap).
//  Guaranteed: store_result and illegal are never both high; at most one cell is written per move.
// TESTING
//  1. Reset, then go_x=1 with sel_x=4 for 1 cycle, then release.
//     -> store_result at t+2, board=18'h00100, turn=1.
//  2. X occupies cell 4, then O presses go_o with sel_o=4.
//     -> illegal pulse, board unchanged, turn stays 1.
//  3. Moves X0, O3, X1, O4, X2.
//     -> game_over=1, winner=01, draw=0.
//     -> further go_x/go_o leave the board unchanged.
//  4. Full 9-move game with no line.
//     -> game_over=1, winner=00, draw=1, move_cnt=9.
//  5. go_x held high for 20 cycles, then go_x and go_o raised together.
//     -> exactly one commit for the held press; then only O (the active player) is accepted.
//  6. new_game asserted during COMMIT, and again during OVER.
//     -> board=0, turn=FIRST_PLAYER, IDLE, no store_result in either case.
//     -> also: reset_b pulsed mid-CHECK clears everything immediately.

Source files
------------

// File: rtl/ttt_turn_ctrl_if.sv
// ---------------------------------------------------------------------------
// ttt_turn_ctrl_if
//   Bundles the player request inputs, the game-control input and the board /
//   result outputs of the tic-tac-toe turn sequencer.
//
//   Signals
//     new_game      master->slave  synchronous clear of board and result
//     go_x, sel_x   master->slave  X move request (level) and target cell 0..8
//     go_o, sel_o   master->slave  O move request (level) and target cell 0..8
//     board         slave->master  cell i = board[2i+1:2i]: 00 empty, 01 X, 10 O
//     turn          slave->master  player to move (0=X, 1=O)
//     store_result  slave->master  1-cycle pulse, move committed
//     illegal       slave->master  1-cycle pulse, request rejected
//     game_over     slave->master  high while the game is finished
//     winner        slave->master  00 none/draw, 01 X, 10 O
//     draw          slave->master  high when finished with no winner
//     dbg_state     slave->master  FSM state: 0 IDLE, 1 CHECK, 2 COMMIT,
//                                  3 EVAL, 4 WAIT_REL, 5 OVER
//     dbg_move_cnt  slave->master  committed moves in the current game
//
//   Handshake: go_x/go_o are level requests (the "valid" side). A request is
//   taken only in IDLE and only from the player whose turn it is; it is
//   answered by exactly one store_result or illegal pulse, after which the
//   requester must drop its go before another request from it is taken. The
//   sequencer has no back-pressure beyond that release requirement.
// ---------------------------------------------------------------------------
interface ttt_turn_ctrl_if;
  logic        new_game;
  logic        go_x;
  logic [3:0]  sel_x;
  logic        go_o;
  logic [3:0]  sel_o;
  logic [17:0] board;
  logic        turn;
  logic        store_result;
  logic        illegal;
  logic        game_over;
  logic [1:0]  winner;
  logic        draw;
  logic [2:0]  dbg_state;
  logic [3:0]  dbg_move_cnt;

  modport master (
    output new_game, go_x, sel_x, go_o, sel_o,
    input  board, turn, store_result, illegal, game_over, winner, draw,
           dbg_state, dbg_move_cnt
  );

  modport slave (
    input  new_game, go_x, sel_x, go_o, sel_o,
    output board, turn, store_result, illegal, game_over, winner, draw,
           dbg_state, dbg_move_cnt
  );
endinterface

// File: rtl/ttt_turn_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_turn_ctrl
//   Game sequencer for the tic-tac-toe datapath. Accepts a move from the
//   player whose turn it is, validates the target cell, writes it into the
//   3x3 board register, evaluates win/draw and alternates turns. The final
//   result is held until new_game.
//
//   Parameters
//     FIRST_PLAYER  player to move after reset/new_game (0=X, 1=O)
//     MAX_MOVES     move count that declares a draw when nobody has a line
//
//   Ports
//     clock    in  system clock, all state on the rising edge
//     reset_b  in  asynchronous reset, active-high
//     bus      ttt_turn_ctrl_if.slave: requests in, board/result out
// ---------------------------------------------------------------------------
module ttt_turn_ctrl #(
  parameter logic FIRST_PLAYER = 1'b0,
  parameter int   MAX_MOVES    = 9
) (
  input  logic           clock,
  input  logic           reset_b,
  ttt_turn_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_COMMIT   = 3'd2,
    S_EVAL     = 3'd3,
    S_WAIT_REL = 3'd4,
    S_OVER     = 3'd5
  } state_t;

  localparam logic [3:0] MAX_CNT  = 4'(MAX_MOVES);
  localparam logic [1:0] CODE_X   = 2'b01;
  localparam logic [1:0] CODE_O   = 2'b10;
  localparam logic [1:0] CODE_NIL = 2'b00;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t      state_q,    state_d;
  logic [17:0] board_q,    board_d;
  logic        turn_q,     turn_d;
  logic [3:0]  move_cnt_q, move_cnt_d;
  logic [1:0]  winner_q,   winner_d;
  logic [3:0]  sel_q,      sel_d;
  // Player who owned the turn when the current request was accepted. The
  // turn flips in EVAL, so WAIT_REL cannot use turn_q to find the mover.
  logic        mover_q,    mover_d;

  logic        store_pulse;
  logic        illegal_pulse;

  // -------------------------------------------------------------------------
  // Board helpers
  // -------------------------------------------------------------------------
  // Cell lookup that tolerates out-of-range indices (returns empty); the
  // range check is done separately, so 9..15 never alias onto real cells.
  function automatic logic [1:0] cell_at(input logic [17:0] b,
                                         input logic [3:0]  idx);
    logic [1:0] c;
    c = CODE_NIL;
    for (int i = 0; i < 9; i++) begin
      if (idx == 4'(i)) c = b[2*i +: 2];
    end
    return c;
  endfunction

  // True when 'code' owns any of the 3 rows, 3 columns or 2 diagonals.
  function automatic logic has_line(input logic [17:0] b,
                                    input logic [1:0]  code);
    logic [8:0] m;
    for (int i = 0; i < 9; i++) begin
      m[i] = (b[2*i +: 2] == code);
    end
    return (m[0] & m[1] & m[2]) |
           (m[3] & m[4] & m[5]) |
           (m[6] & m[7] & m[8]) |
           (m[0] & m[3] & m[6]) |
           (m[1] & m[4] & m[7]) |
           (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) |
           (m[2] & m[4] & m[6]);
  endfunction

  logic       sel_bad;
  logic       mover_go;
  logic [1:0] mover_code;

  always_comb begin
    sel_bad    = (sel_q > 4'd8) || (cell_at(board_q, sel_q) != CODE_NIL);
    mover_go   = mover_q ? bus.go_o : bus.go_x;
    mover_code = mover_q ? CODE_O : CODE_X;
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset_b) begin
    if (reset_b) begin
      state_q    <= S_IDLE;
      board_q    <= '0;
      turn_q     <= FIRST_PLAYER;
      move_cnt_q <= '0;
      winner_q   <= CODE_NIL;
      sel_q      <= '0;
      mover_q    <= FIRST_PLAYER;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      turn_q     <= turn_d;
      move_cnt_q <= move_cnt_d;
      winner_q   <= winner_d;
      sel_q      <= sel_d;
      mover_q    <= mover_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and pulses
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    turn_d        = turn_q;
    move_cnt_d    = move_cnt_q;
    winner_d      = winner_q;
    sel_d         = sel_q;
    mover_d       = mover_q;
    store_pulse   = 1'b0;
    illegal_pulse = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Only the active player's request is looked at; the other go is
        // ignored even when both are high.
        if (!turn_q && bus.go_x) begin
          sel_d   = bus.sel_x;
          mover_d = 1'b0;
          state_d = S_CHECK;
        end else if (turn_q && bus.go_o) begin
          sel_d   = bus.sel_o;
          mover_d = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (sel_bad) begin
          illegal_pulse = 1'b1;
          state_d       = S_WAIT_REL;
        end else begin
          state_d = S_COMMIT;
        end
      end

      S_COMMIT: begin
        store_pulse = 1'b1;
        // sel_q was range-checked in CHECK, so exactly one cell matches.
        for (int i = 0; i < 9; i++) begin
          if (sel_q == 4'(i)) board_d[2*i +: 2] = turn_q ? CODE_O : CODE_X;
        end
        if (move_cnt_q < MAX_CNT) move_cnt_d = move_cnt_q + 4'd1;
        state_d = S_EVAL;
      end

      S_EVAL: begin
        if (has_line(board_q, mover_code)) begin
          winner_d = mover_code;
          state_d  = S_OVER;
        end else if (move_cnt_q >= MAX_CNT) begin
          winner_d = CODE_NIL;
          state_d  = S_OVER;
        end else begin
          turn_d  = ~turn_q;
          state_d = S_WAIT_REL;
        end
      end

      S_WAIT_REL: begin
        // One press yields one move: wait for the requester to let go.
        if (!mover_go) state_d = S_IDLE;
      end

      S_OVER: begin
        // Board and result frozen; requests ignored until new_game.
        state_d = S_OVER;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // new_game overrides everything, including a move caught mid-COMMIT,
    // which is discarded without a store pulse.
    if (bus.new_game) begin
      state_d       = S_IDLE;
      board_d       = '0;
      turn_d        = FIRST_PLAYER;
      move_cnt_d    = '0;
      winner_d      = CODE_NIL;
      sel_d         = '0;
      mover_d       = FIRST_PLAYER;
      store_pulse   = 1'b0;
      illegal_pulse = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    bus.board        = board_q;
    bus.turn         = turn_q;
    bus.store_result = store_pulse;
    bus.illegal      = illegal_pulse;
    bus.game_over    = (state_q == S_OVER);
    bus.winner       = winner_q;
    bus.draw         = (state_q == S_OVER) && (winner_q == CODE_NIL);
    bus.dbg_state    = state_q;
    bus.dbg_move_cnt = move_cnt_q;
  end

endmodule
